iob_fifo_asym_ctrl: RTL and testbench

//  Single-clock FIFO controller for an asymmetric two-port RAM (W_DATA_W write side, R_DATA_W read side).

---
 rtl/iob_fifo_asym_ctrl_pkg.sv | 16 +
 rtl/iob_fifo_asym_level.sv | 59 +++++
 rtl/iob_fifo_asym_ctrl.sv | 86 ++++++++
 tb/tb_iob_fifo_asym_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/iob_fifo_asym_ctrl_pkg.sv
// iob_fifo_asym_ctrl_pkg: width helpers shared by the asymmetric FIFO controller, its RAM and bench
// Provides IOB_MAX/IOB_MIN and the ratio / per-side address width derivation.
`ifndef IOB_MAX
`define IOB_MAX(a, b) (((a) > (b)) ? (a) : (b))
`endif
`ifndef IOB_MIN
`define IOB_MIN(a, b) (((a) < (b)) ? (a) : (b))
`endif
package iob_fifo_asym_ctrl_pkg;
  function automatic int asym_ratio(input int side_w, input int other_w);
    return side_w / `IOB_MIN(side_w, other_w);
  endfunction
  function automatic int asym_addr_w(input int addr_w, input int side_w, input int other_w);
    return addr_w - $clog2(asym_ratio(side_w, other_w));
  endfunction
endpackage

// File: rtl/iob_fifo_asym_level.sv
// iob_fifo_asym_level: fill level counter (MINDATA_W units) with registered full/empty flags
// Almost-full/almost-empty registers exist only with IOB_FIFO_ASYM_CTRL_THRESH_EN.
module iob_fifo_asym_level #(
  parameter int ADDR_W = 10,
  parameter int W_RATIO = 4,
  parameter int R_RATIO = 1
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            cke_i,
  input  logic            rst_i,
  input  logic            w_acc_i,
  input  logic            r_acc_i,
`ifdef IOB_FIFO_ASYM_CTRL_THRESH_EN
  input  logic [ADDR_W:0] almost_full_lvl_i,
  input  logic [ADDR_W:0] almost_empty_lvl_i,
  output logic            almost_full_o,
  output logic            almost_empty_o,
`endif
  output logic [ADDR_W:0] level_o,
  output logic            w_full_o,
  output logic            r_empty_o
);
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] WR = (ADDR_W + 1)'(W_RATIO);
  localparam logic [ADDR_W:0] RR = (ADDR_W + 1)'(R_RATIO);
  logic [ADDR_W:0] level_q, level_d;
  logic            w_full_q, w_full_d, r_empty_q, r_empty_d;
  // acceptance is gated by the flags, so the sum never leaves [0, CAP]
  assign level_d   = level_q + (w_acc_i ? WR : '0) - (r_acc_i ? RR : '0);
  assign w_full_d  = level_d > CAP - WR;
  assign r_empty_d = level_d < RR;
  assign level_o   = level_q;
  assign w_full_o  = w_full_q;
  assign r_empty_o = r_empty_q;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      level_q   <= '0;
      w_full_q  <= 1'b0;
      r_empty_q <= 1'b1;
    end else if (cke_i) begin
      level_q   <= rst_i ? '0 : level_d;
      w_full_q  <= rst_i ? 1'b0 : w_full_d;
      r_empty_q <= rst_i ? 1'b1 : r_empty_d;
    end
`ifdef IOB_FIFO_ASYM_CTRL_THRESH_EN
  logic almost_full_q, almost_empty_q;
  assign almost_full_o  = almost_full_q;
  assign almost_empty_o = almost_empty_q;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else if (cke_i) begin
      almost_full_q  <= rst_i ? 1'b0 : level_d >= almost_full_lvl_i;
      almost_empty_q <= rst_i ? 1'b1 : level_d <= almost_empty_lvl_i;
    end
`endif
endmodule

// File: rtl/iob_fifo_asym_ctrl.sv
// iob_fifo_asym_ctrl: single-clock FIFO controller for an external asymmetric two-port RAM
// Optional almost-full/almost-empty thresholds are enabled with IOB_FIFO_ASYM_CTRL_THRESH_EN.
module iob_fifo_asym_ctrl
  import iob_fifo_asym_ctrl_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W = 10,
  localparam int W_ADDR_W = asym_addr_w(ADDR_W, W_DATA_W, R_DATA_W),
  localparam int R_ADDR_W = asym_addr_w(ADDR_W, R_DATA_W, W_DATA_W)
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                w_en_i,
  input  logic [W_DATA_W-1:0] w_data_i,
  output logic                w_full_o,
  input  logic                r_en_i,
  output logic [R_DATA_W-1:0] r_data_o,
  output logic                r_empty_o,
`ifdef IOB_FIFO_ASYM_CTRL_THRESH_EN
  input  logic [ADDR_W:0]     almost_full_lvl_i,
  input  logic [ADDR_W:0]     almost_empty_lvl_i,
  output logic                almost_full_o,
  output logic                almost_empty_o,
`endif
  output logic [ADDR_W:0]     level_o,
  output logic                ext_mem_w_en_o,
  output logic [W_ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [W_DATA_W-1:0] ext_mem_w_data_o,
  output logic                ext_mem_r_en_o,
  output logic [R_ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [R_DATA_W-1:0] ext_mem_r_data_i
);
  localparam int W_RATIO = asym_ratio(W_DATA_W, R_DATA_W);
  localparam int R_RATIO = asym_ratio(R_DATA_W, W_DATA_W);
  logic                w_acc, r_acc, r_valid_q;
  logic [W_ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [R_ADDR_W-1:0] r_ptr_q, r_ptr_d;
  logic [R_DATA_W-1:0] r_hold_q;
  assign w_acc = w_en_i & ~w_full_o & cke_i;
  assign r_acc = r_en_i & ~r_empty_o & cke_i;
  assign w_ptr_d = w_ptr_q + W_ADDR_W'(w_acc);
  assign r_ptr_d = r_ptr_q + R_ADDR_W'(r_acc);
  assign ext_mem_w_en_o   = w_acc;
  assign ext_mem_w_addr_o = w_ptr_q;
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = r_acc;
  assign ext_mem_r_addr_o = r_ptr_q;
  // RAM output is live only the cycle after a read; otherwise show the captured copy
  assign r_data_o = r_valid_q ? ext_mem_r_data_i : r_hold_q;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      r_valid_q <= 1'b0;
      r_hold_q  <= '0;
    end else if (cke_i) begin
      w_ptr_q   <= rst_i ? '0 : w_ptr_d;
      r_ptr_q   <= rst_i ? '0 : r_ptr_d;
      r_valid_q <= rst_i ? 1'b0 : r_acc;
      r_hold_q  <= rst_i ? '0 : r_data_o;
    end
  iob_fifo_asym_level #(
    .ADDR_W (ADDR_W),
    .W_RATIO(W_RATIO),
    .R_RATIO(R_RATIO)
  ) u_level (
    .clk_i             (clk_i),
    .arst_i            (arst_i),
    .cke_i             (cke_i),
    .rst_i             (rst_i),
    .w_acc_i           (w_acc),
    .r_acc_i           (r_acc),
`ifdef IOB_FIFO_ASYM_CTRL_THRESH_EN
    .almost_full_lvl_i (almost_full_lvl_i),
    .almost_empty_lvl_i(almost_empty_lvl_i),
    .almost_full_o     (almost_full_o),
    .almost_empty_o    (almost_empty_o),
`endif
    .level_o           (level_o),
    .w_full_o          (w_full_o),
    .r_empty_o         (r_empty_o)
  );
endmodule

// File: tb/tb_iob_fifo_asym_ctrl.sv
// tb_iob_fifo_asym_ctrl: wide-write (32/8) and narrow-write (8/32) FIFOs against byte-queue models
// Threshold outputs are exercised when IOB_FIFO_ASYM_CTRL_THRESH_EN is defined.
module tb_iob_fifo_asym_ctrl;
  localparam int CAP = 1024;
  logic clk = 1'b0, arst = 1'b1, rst = 1'b0, cke = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;

  logic        a_wen, a_ren, a_full, a_empty, a_mwen, a_mren;
  logic [31:0] a_wdata, a_mwdata;
  logic [7:0]  a_rdata, a_mrdata;
  logic [10:0] a_level;
  logic [7:0]  a_mwaddr;
  logic [9:0]  a_mraddr;
  logic        b_wen, b_ren, b_full, b_empty, b_mwen, b_mren;
  logic [7:0]  b_wdata, b_mwdata;
  logic [31:0] b_rdata, b_mrdata;
  logic [10:0] b_level;
  logic [9:0]  b_mwaddr;
  logic [7:0]  b_mraddr;
`ifdef IOB_FIFO_ASYM_CTRL_THRESH_EN
  logic a_af, a_ae, b_af, b_ae;
  logic [10:0] af_lvl = 11'd1000, ae_lvl = 11'd4;
`endif

  iob_fifo_asym_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(10)) dut_a (
    .clk_i(clk), .arst_i(arst), .cke_i(cke), .rst_i(rst),
    .w_en_i(a_wen), .w_data_i(a_wdata), .w_full_o(a_full),
    .r_en_i(a_ren), .r_data_o(a_rdata), .r_empty_o(a_empty),
`ifdef IOB_FIFO_ASYM_CTRL_THRESH_EN
    .almost_full_lvl_i(af_lvl), .almost_empty_lvl_i(ae_lvl),
    .almost_full_o(a_af), .almost_empty_o(a_ae),
`endif
    .level_o(a_level),
    .ext_mem_w_en_o(a_mwen), .ext_mem_w_addr_o(a_mwaddr), .ext_mem_w_data_o(a_mwdata),
    .ext_mem_r_en_o(a_mren), .ext_mem_r_addr_o(a_mraddr), .ext_mem_r_data_i(a_mrdata)
  );
  iob_fifo_asym_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(10)) dut_b (
    .clk_i(clk), .arst_i(arst), .cke_i(cke), .rst_i(rst),
    .w_en_i(b_wen), .w_data_i(b_wdata), .w_full_o(b_full),
    .r_en_i(b_ren), .r_data_o(b_rdata), .r_empty_o(b_empty),
`ifdef IOB_FIFO_ASYM_CTRL_THRESH_EN
    .almost_full_lvl_i(af_lvl), .almost_empty_lvl_i(ae_lvl),
    .almost_full_o(b_af), .almost_empty_o(b_ae),
`endif
    .level_o(b_level),
    .ext_mem_w_en_o(b_mwen), .ext_mem_w_addr_o(b_mwaddr), .ext_mem_w_data_o(b_mwdata),
    .ext_mem_r_en_o(b_mren), .ext_mem_r_addr_o(b_mraddr), .ext_mem_r_data_i(b_mrdata)
  );

  // asymmetric RAMs, little-endian byte lanes, registered read
  logic [7:0] mem_a [CAP];
  logic [7:0] mem_b [CAP];
  always @(posedge clk) begin
    if (a_mwen) for (int k = 0; k < 4; k++) mem_a[int'(a_mwaddr) * 4 + k] <= a_mwdata[8*k+:8];
    if (a_mren) a_mrdata <= mem_a[a_mraddr];
    if (b_mwen) mem_b[b_mwaddr] <= b_mwdata;
    if (b_mren) for (int k = 0; k < 4; k++) b_mrdata[8*k+:8] <= mem_b[int'(b_mraddr) * 4 + k];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: contents as a byte queue; scoreboards of expected read words
  logic [7:0]  qa[$], qb[$];
  logic [7:0]  sba[$];
  logic [31:0] sbb[$];
  logic [7:0]  a_last = '0;
  logic [31:0] b_last = '0;
  int a_wcnt = 0, b_wcnt = 0;

  logic a_rv = 1'b0, b_rv = 1'b0;
  always @(posedge clk or posedge arst) begin
    a_rv <= arst ? 1'b0 : a_mren;
    b_rv <= arst ? 1'b0 : b_mren;
  end
  always @(negedge clk) begin
    if (a_rv) begin
      if (sba.size() == 0) check("a_sb_underflow", 1, 0);
      else a_last = sba.pop_front();
    end
    check("a_r_data", a_rdata, a_last);
    if (b_rv) begin
      if (sbb.size() == 0) check("b_sb_underflow", 1, 0);
      else b_last = sbb.pop_front();
    end
    check("b_r_data", b_rdata, b_last);
  end

  task automatic step_a(input logic we, input logic [31:0] wd, input logic re);
    bit wacc, racc;
    a_wen = we; a_wdata = wd; a_ren = re;
    wacc = cke && we && !(qa.size() > CAP - 4);
    racc = cke && re && qa.size() >= 1;
    #1;
    check("a_mem_w_en", a_mwen, wacc);
    check("a_mem_r_en", a_mren, racc);
    if (wacc) begin
      check("a_mem_w_addr", a_mwaddr, a_wcnt % 256);
      check("a_mem_w_data", a_mwdata, wd);
    end
    if (racc) sba.push_back(qa.pop_front());
    if (wacc) begin
      for (int k = 0; k < 4; k++) qa.push_back(wd[8*k+:8]);
      a_wcnt++;
    end
    @(posedge clk); #1;
    check("a_level", a_level, qa.size());
    check("a_full", a_full, qa.size() > CAP - 4);
    check("a_empty", a_empty, qa.size() < 1);
`ifdef IOB_FIFO_ASYM_CTRL_THRESH_EN
    check("a_almost_full", a_af, qa.size() >= 1000);
    check("a_almost_empty", a_ae, qa.size() <= 4);
`endif
    @(negedge clk);
  endtask

  task automatic step_b(input logic we, input logic [7:0] wd, input logic re);
    bit wacc, racc;
    logic [31:0] e;
    b_wen = we; b_wdata = wd; b_ren = re;
    wacc = cke && we && !(qb.size() > CAP - 1);
    racc = cke && re && qb.size() >= 4;
    #1;
    check("b_mem_w_en", b_mwen, wacc);
    check("b_mem_r_en", b_mren, racc);
    if (wacc) check("b_mem_w_addr", b_mwaddr, b_wcnt % 1024);
    if (racc) begin
      for (int k = 0; k < 4; k++) e[8*k+:8] = qb.pop_front();
      sbb.push_back(e);
    end
    if (wacc) begin
      qb.push_back(wd);
      b_wcnt++;
    end
    @(posedge clk); #1;
    check("b_level", b_level, qb.size());
    check("b_full", b_full, qb.size() > CAP - 1);
    check("b_empty", b_empty, qb.size() < 4);
`ifdef IOB_FIFO_ASYM_CTRL_THRESH_EN
    check("b_almost_full", b_af, qb.size() >= 1000);
    check("b_almost_empty", b_ae, qb.size() <= 4);
`endif
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    check("rst_a_level", a_level, 0);
    check("rst_a_empty", a_empty, 1);
    check("rst_a_full", a_full, 0);
    check("rst_a_r_data", a_rdata, 0);
    check("rst_b_level", b_level, 0);
    check("rst_b_empty", b_empty, 1);
    check("rst_b_full", b_full, 0);
    check("rst_b_r_data", b_rdata, 0);
  endtask

  task automatic pulse_reset();
    #2 arst = 1'b1;
    #1 check_reset_state();
    qa.delete(); sba.delete(); qb.delete(); sbb.delete();
    a_last = '0; b_last = '0; a_wcnt = 0; b_wcnt = 0;
    #1 arst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_wen = 0; a_ren = 0; a_wdata = '0; b_wen = 0; b_ren = 0; b_wdata = '0;
    repeat (2) @(negedge clk);
    #1 check_reset_state();
    arst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) step_a(1, 32'(i + 10), 0);
    check("a_full_after_256", a_full, 1);
    check("a_level_after_256", a_level, 1024);
    step_a(1, 32'hdead_beef, 0);
    check("a_257th_level", a_level, 1024);
    for (int i = 0; i < 1024; i++) step_a(0, 0, 1);
    check("a_empty_after_1024", a_empty, 1);
    step_a(0, 0, 1);
    check("a_extra_read_hold", a_rdata, 8'd0 + 8'((255 + 10) >> 24));
    while (qa.size() < 1020) step_a(1, $urandom, 0);
    for (int i = 0; i < 20; i++) step_a(1, $urandom, 1);
    while (qa.size() > 0) step_a(0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      cke = ($urandom % 8) != 0;
      step_a(1'($urandom), $urandom, 1'($urandom));
    end
    cke = 1'b1;
    while (qa.size() > 500) step_a(0, 0, 1);
    while (qa.size() < 500) step_a(1, $urandom, 0);
    check("a_level_500", a_level, 500);
    pulse_reset();
    step_a(1, 32'h0403_0201, 0);
    for (int i = 0; i < 4; i++) step_a(0, 0, 1);
    for (int i = 0; i < 3; i++) step_b(1, 8'(8'hb0 + i), 0);
    check("b_empty_3_bytes", b_empty, 1);
    step_b(1, 8'hb3, 0);
    check("b_nonempty_4_bytes", b_empty, 0);
    step_b(0, 0, 1);
    step_b(0, 0, 0);
    check("b_word_order", b_rdata, 32'hb3b2_b1b0);
    for (int i = 0; i < 1500; i++) begin
      cke = ($urandom % 8) != 0;
      step_b(($urandom % 4) != 0, 8'($urandom), 1'($urandom));
    end
    cke = 1'b1;
    while (qb.size() >= 4) step_b(0, 0, 1);
    step_b(0, 0, 0);
    check("a_sb_drained", sba.size(), 0);
    check("b_sb_drained", sbb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
